chunked_ripple_adder: RTL and testbench
=======================================

# chunked_ripple_adder

Parametrised multi-cycle adder/subtractor that resolves a WIDTH-bit add in WIDTH/CHUNK clock cycles, one CHUNK-bit ripple slice per cycle, LSB slice first. It is the sequential, handshaked successor to the team's 4-bit ripple-carry adder: it adds width/chunk parametrisation, subtract mode, carry-in, signed-overflow detection and a start/busy/done protocol. It sits beside the ALU datapath wherever a narrow carry chain must serve a wide operand.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of CHUNK
- CHUNK, 4, bits resolved per cycle; 1 ≤ CHUNK ≤ WIDTH
- NCH (localparam), WIDTH/CHUNK, number of slice cycles
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only when not busy
- sub  in  1  0: a+b+cin; 1: a−b (cin ignored)
- cin  in  1  carry-in for add mode
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at an edge: latch a; latch b' = sub ? ~b : b; carry ← sub ? 1 : cin; slice index ← 0; go to RUN; busy ← 1.
- RUN, each edge: slice k computes a[k] + b'[k] + carry (CHUNK+1 bits); low CHUNK bits go into the internal accumulator at slice k; carry ← top bit; k ← k+1.
- On the edge that processes slice NCH−1: load sum ← accumulator (including the final slice), cout ← final carry, ovf ← (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]); busy ← 0; done ← 1; go to DONE.
- DONE lasts one cycle, then IDLE. start=1 in DONE is accepted (back-to-back) exactly as in IDLE.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- sum, cout and ovf hold the previous result throughout RUN. They change only on completion or reset, never showing partial values.
- Width rules: slice adder is CHUNK+1 bits; the carry register is 1 bit; the index counter is clog2(NCH) bits, minimum 1.

## Timing
- Reset (async assert, any state): state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, accumulator/carry/index 0.
- Reset mid-RUN aborts the operation: no done is produced and outputs are zeroed.
- Latency: start sampled at edge E0 → busy high after E0 → done high and result valid after edge E0+NCH, for one cycle. busy falls at the same edge done rises.
- Throughput: one result per NCH+1 cycles with back-to-back start.
- CHUNK = WIDTH (NCH = 1): RUN lasts one cycle; done rises after E0+1.
- done is never asserted together with busy.

## Test plan
Defaults are WIDTH=16, CHUNK=4, so done is expected after edge E0+4.
- a=0x0000, b=0xFFFF, sub=0, cin=0 → sum=0xFFFF, cout=0, ovf=0. done pulses exactly 1 cycle, 4 edges after the start edge; busy is high for those 4 cycles.
- a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0. a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1.
- sub=1: a=0x000A, b=0x000F → sum=0xFFFB, cout=0, ovf=0. a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. cin=1 is applied and must have no effect.
- Protocol checks:
  - Start pulses and operand changes during RUN are ignored, and the result is unchanged.
  - start held high in the DONE cycle begins a new operation immediately.
  - sum holds the old result during RUN.
- Assert rst in the 2nd RUN cycle → outputs go to 0 asynchronously and no done appears. A fresh start after release completes normally.
- Parameter sweep: CHUNK ∈ {1, 4, 16} with WIDTH=16, plus WIDTH=32/CHUNK=8.
  - 1000 random add/sub ops per configuration, checked against a behavioural {cout, sum} = a ± b (+cin) and the signed-overflow reference.
  - Latency must equal NCH edges in every case.

Source files
------------

// File: rtl/chunked_ripple_adder_if.sv
// ---------------------------------------------------------------------------
// chunked_ripple_adder_if
//
// Request/response bundle for the chunked ripple adder.
//
// Handshake: the master raises start with sub/cin/a/b valid. The request is
// taken on any rising clock edge where busy is low; while busy is high, start
// and the operands are ignored. When the result is ready, done pulses high for
// exactly one cycle with sum/cout/ovf valid. Those outputs keep that value
// until the next completion. done and busy are never high together.
//
// Signals
//   start : request strobe (master -> slave)
//   sub   : 0 = a + b + cin, 1 = a - b (master -> slave)
//   cin   : carry-in for add mode (master -> slave)
//   a, b  : WIDTH-bit operands (master -> slave)
//   busy  : operation in progress (slave -> master)
//   done  : one-cycle result-valid pulse (slave -> master)
//   sum   : WIDTH-bit result (slave -> master)
//   cout  : carry out of the MSB; in sub mode 1 means no borrow (slave -> master)
//   ovf   : two's-complement signed overflow (slave -> master)
// ---------------------------------------------------------------------------
interface chunked_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_ripple_adder.sv
// ---------------------------------------------------------------------------
// chunked_ripple_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit add is resolved one CHUNK-bit
// ripple slice per clock, least-significant slice first, so a result takes
// NCH = WIDTH/CHUNK cycles after the request is taken.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : slave side of chunked_ripple_adder_if (start/sub/cin/a/b in,
//               busy/done/sum/cout/ovf out)
//   dbg_state : current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Parameters
//   WIDTH : operand/result width, an integer multiple of CHUNK
//   CHUNK : bits resolved per cycle, 1..WIDTH
// ---------------------------------------------------------------------------
module chunked_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  chunked_ripple_adder_if.slave   bus,
  output logic [1:0]              dbg_state
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // FSM-to-datapath controls
  logic load;    // capture a new request
  logic step;    // process the current slice
  logic finish;  // current slice is the last one; publish the result

  // Operation context, frozen at request time so operand changes mid-run
  // cannot leak into the result.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // already inverted for subtract
  logic [WIDTH-1:0] acc;     // slices resolved so far
  logic             carry;
  logic [IDX_W-1:0] idx;

  // Published result; only ever written on completion or reset.
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Slice datapath
  int               base;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice;
  logic [WIDTH-1:0] acc_next;
  logic             last;
  logic             ovf_next;

  // -------------------------------------------------------------------------
  // Slice adder: one CHUNK+1 bit ripple add per cycle. acc_next already holds
  // the current slice so the final result can be published on the same edge
  // that resolves the last slice.
  // -------------------------------------------------------------------------
  always_comb begin
    base     = int'(idx) * CHUNK;
    a_slice  = a_q[base +: CHUNK];
    b_slice  = b_q[base +: CHUNK];
    slice    = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
    acc_next = acc;
    acc_next[base +: CHUNK] = slice[CHUNK-1:0];
  end

  assign last = (idx == IDX_W'(NCH - 1));

  // Overflow uses the effective (possibly inverted) B: operands of equal
  // sign producing a result of the other sign.
  assign ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (acc_next[WIDTH-1] != a_q[WIDTH-1]);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control decode. DONE accepts a new request exactly
  // like IDLE, which gives back-to-back throughput of one result per NCH+1.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Working registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (load) begin
      a_q   <= bus.a;
      // Subtract is a + ~b + 1; cin is ignored in that mode.
      b_q   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1 : bus.cin;
      acc   <= '0;
      idx   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      carry <= slice[CHUNK];
      idx   <= idx + IDX_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Result registers: hold the previous result through RUN so no partial
  // value is ever visible.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (finish) begin
      sum_q  <= acc_next;
      cout_q <= slice[CHUNK];
      ovf_q  <= ovf_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. busy/done decode straight from the state register, so busy falls
  // on the same edge done rises and the two are never high together.
  // -------------------------------------------------------------------------
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_ripple_adder
//
// Four adder instances share clock, reset and operand buses; each has its own
// start strobe so a test exercises one configuration at a time:
//   cfg 0: WIDTH=16 CHUNK=1   cfg 1: WIDTH=16 CHUNK=4 (directed tests)
//   cfg 2: WIDTH=16 CHUNK=16  cfg 3: WIDTH=32 CHUNK=8
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_chunked_ripple_adder;

  localparam int NCFG = 4;
  localparam int DEF  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- shared stimulus / per-config observation ----------------
  logic [NCFG-1:0] start_v;
  logic [NCFG-1:0] busy_v;
  logic [NCFG-1:0] done_v;
  logic [NCFG-1:0] cout_v;
  logic [NCFG-1:0] ovf_v;
  logic [31:0]     sum_v [NCFG];
  logic [1:0]      st_v  [NCFG];
  logic [31:0]     a_in;
  logic [31:0]     b_in;
  logic            sub_in;
  logic            cin_in;

  int n_cmp = 0;
  int n_err = 0;

  genvar gi;
  for (gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = (gi == 3) ? 32 : 16;
    localparam int C = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 16 : 8;

    chunked_ripple_adder_if #(.WIDTH(W)) bus ();

    assign bus.start   = start_v[gi];
    assign bus.sub     = sub_in;
    assign bus.cin     = cin_in;
    assign bus.a       = a_in[W-1:0];
    assign bus.b       = b_in[W-1:0];
    assign busy_v[gi]  = bus.busy;
    assign done_v[gi]  = bus.done;
    assign cout_v[gi]  = bus.cout;
    assign ovf_v[gi]   = bus.ovf;
    assign sum_v[gi]   = 32'(bus.sum);

    chunked_ripple_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (st_v[gi])
    );
  end

  function automatic int cfg_w(int i);
    return (i == 3) ? 32 : 16;
  endfunction

  function automatic int cfg_nch(int i);
    return (i == 0) ? 16 : (i == 1) ? 4 : (i == 2) ? 1 : 4;
  endfunction

  // ---------------- reference model ----------------
  // Plain integer arithmetic: {ovf, cout, sum}. cout in subtract mode is
  // "no borrow" (a >= b unsigned); ovf is the true signed result leaving the
  // representable range.
  function automatic logic [33:0] ref_model(int w, logic [31:0] a, logic [31:0] b,
                                            logic s, logic c);
    longint lim, ua, ub, full, sa, sb, sres;
    logic   co, ov;
    lim = longint'(1) << w;
    ua  = longint'(a) & (lim - 1);
    ub  = longint'(b) & (lim - 1);
    if (s) begin
      full = ua - ub;
      co   = (ua >= ub);
    end else begin
      full = ua + ub + longint'(c);
      co   = (full >= lim);
    end
    sa   = (ua >= lim / 2) ? ua - lim : ua;
    sb   = (ub >= lim / 2) ? ub - lim : ub;
    sres = s ? (sa - sb) : (sa + sb + longint'(c));
    ov   = (sres >= lim / 2) || (sres < -(lim / 2));
    return {ov, co, 32'(full & (lim - 1))};
  endfunction

  function automatic logic [31:0] rand_operand(int w);
    logic [31:0] one;
    one = 32'h1;
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return one << (w - 1);
      2:       return (one << (w - 1)) - 32'h1;
      3:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one request on config idx and waits (bounded) for done.
  // lat = edges from the start edge to the edge raising done, -1 on timeout.
  // proto_ok drops if busy is low or done is high before completion, or if
  // busy is still high when done rises.
  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c, output int lat,
                       output logic proto_ok, output logic [31:0] r_sum,
                       output logic r_cout, output logic r_ovf);
    @(negedge clk);
    a_in = a; b_in = b; sub_in = s; cin_in = c;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    proto_ok = busy_v[idx] && !done_v[idx];
    lat = -1;
    for (int n = 1; n <= cfg_nch(idx) + 4; n++) begin
      @(negedge clk);
      if (done_v[idx]) begin
        lat = n;
        if (busy_v[idx]) proto_ok = 1'b0;
        break;
      end
      if (!busy_v[idx]) proto_ok = 1'b0;
    end
    r_sum  = sum_v[idx];
    r_cout = cout_v[idx];
    r_ovf  = ovf_v[idx];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      n_cmp += 4;
      if (busy_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy cfg%0d: got %b want 0", i, busy_v[i]); end
      if (done_v[i] !== 1'b0) begin n_err++; $display("FAIL reset_done cfg%0d: got %b want 0", i, done_v[i]); end
      if (sum_v[i] !== 32'h0) begin n_err++; $display("FAIL reset_sum cfg%0d: got %h want 0", i, sum_v[i]); end
      if ({cout_v[i], ovf_v[i]} !== 2'b00) begin n_err++; $display("FAIL reset_flags cfg%0d: got %b want 00", i, {cout_v[i], ovf_v[i]}); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int lat; logic ok; logic [31:0] s; logic co, ov;
    do_op(DEF, 32'h0000, 32'hFFFF, 1'b0, 1'b0, lat, ok, s, co, ov);
    n_cmp += 4;
    if (s !== 32'hFFFF) begin n_err++; $display("FAIL basic_sum: got %h want ffff", s); end
    if ({co, ov} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b want 00", {co, ov}); end
    if (lat !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", lat); end
    if (ok !== 1'b1) begin n_err++; $display("FAIL basic_busy_window: got %b want 1", ok); end
    @(negedge clk);
    n_cmp++;
    if ({busy_v[DEF], done_v[DEF]} !== 2'b00) begin
      n_err++; $display("FAIL basic_done_width: got busy/done %b want 00", {busy_v[DEF], done_v[DEF]});
    end
  endtask

  task automatic test_add_cases();
    logic [31:0] ta [2]; logic [31:0] tb [2]; logic tc [2]; logic [33:0] te [2];
    int lat; logic ok; logic [31:0] s; logic co, ov;
    ta = '{32'hFFFF, 32'h7FFF}; tb = '{32'hFFFF, 32'h0001}; tc = '{1'b1, 1'b0};
    te = '{{1'b0, 1'b1, 32'hFFFF}, {1'b1, 1'b0, 32'h8000}};
    for (int i = 0; i < 2; i++) begin
      do_op(DEF, ta[i], tb[i], 1'b0, tc[i], lat, ok, s, co, ov);
      n_cmp += 2;
      if ({ov, co, s} !== te[i]) begin n_err++; $display("FAIL add_case%0d: got %h want %h", i, {ov, co, s}, te[i]); end
      if (lat !== 4) begin n_err++; $display("FAIL add_case%0d_latency: got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_sub_cases();
    logic [31:0] ta [2]; logic [31:0] tb [2]; logic [33:0] te [2];
    int lat; logic ok; logic [31:0] s; logic co, ov;
    ta = '{32'h000A, 32'h8000}; tb = '{32'h000F, 32'h0001};
    te = '{{1'b0, 1'b0, 32'hFFFB}, {1'b1, 1'b1, 32'h7FFF}};
    for (int i = 0; i < 2; i++) begin
      // cin=1 must have no effect in subtract mode
      do_op(DEF, ta[i], tb[i], 1'b1, 1'b1, lat, ok, s, co, ov);
      n_cmp++;
      if ({ov, co, s} !== te[i]) begin n_err++; $display("FAIL sub_case%0d: got %h want %h", i, {ov, co, s}, te[i]); end
    end
  endtask

  task automatic test_ignore_during_run();
    int lat; logic ok; logic [31:0] s; logic co, ov;
    int n_done;
    do_op(DEF, 32'h1111, 32'h2222, 1'b0, 1'b0, lat, ok, s, co, ov);
    n_cmp++;
    if (s !== 32'h3333) begin n_err++; $display("FAIL ignore_prev_sum: got %h want 3333", s); end
    @(negedge clk);
    a_in = 32'h1234; b_in = 32'h0F0F; sub_in = 1'b0; cin_in = 1'b1;
    start_v[DEF] = 1'b1;
    @(negedge clk);
    n_done = -1;
    for (int n = 1; n <= 10; n++) begin
      // junk operands and start pulses while the operation runs
      a_in = $urandom; b_in = $urandom; sub_in = 1'($urandom); cin_in = 1'($urandom);
      start_v[DEF] = 1'($urandom);
      @(negedge clk);
      if (done_v[DEF]) begin
        n_done = n;
        break;
      end
      n_cmp++;
      if (sum_v[DEF] !== 32'h3333) begin n_err++; $display("FAIL hold_during_run n=%0d: got %h want 3333", n, sum_v[DEF]); end
    end
    start_v[DEF] = 1'b0;
    n_cmp += 2;
    if (n_done !== 4) begin n_err++; $display("FAIL ignore_latency: got %0d want 4", n_done); end
    if ({ovf_v[DEF], cout_v[DEF], sum_v[DEF]} !== {2'b00, 32'h2144}) begin
      n_err++; $display("FAIL ignore_result: got %h want 000002144", {ovf_v[DEF], cout_v[DEF], sum_v[DEF]});
    end
    @(negedge clk);
    n_cmp++;
    if (busy_v[DEF] !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart: got busy %b want 0", busy_v[DEF]); end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    @(negedge clk);
    a_in = 32'h0100; b_in = 32'h0023; sub_in = 1'b0; cin_in = 1'b0;
    start_v[DEF] = 1'b1;
    @(negedge clk);
    start_v[DEF] = 1'b0;
    n1 = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done_v[DEF]) begin n1 = n; break; end
    end
    n_cmp += 2;
    if (n1 !== 4) begin n_err++; $display("FAIL b2b_first_latency: got %0d want 4", n1); end
    if (sum_v[DEF] !== 32'h0123) begin n_err++; $display("FAIL b2b_first_sum: got %h want 0123", sum_v[DEF]); end
    // start presented during the DONE cycle
    a_in = 32'h0050; b_in = 32'h0060; sub_in = 1'b1;
    start_v[DEF] = 1'b1;
    @(negedge clk);
    start_v[DEF] = 1'b0;
    n_cmp++;
    if (busy_v[DEF] !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b want 1", busy_v[DEF]); end
    n2 = -1;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (done_v[DEF]) begin n2 = n; break; end
    end
    n_cmp += 2;
    if (n2 !== 5) begin n_err++; $display("FAIL b2b_throughput: got %0d want 5", n2); end
    if ({ovf_v[DEF], cout_v[DEF], sum_v[DEF]} !== {2'b00, 32'hFFF0}) begin
      n_err++; $display("FAIL b2b_second_result: got %h want 00000fff0", {ovf_v[DEF], cout_v[DEF], sum_v[DEF]});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic ok; logic [31:0] s; logic co, ov;
    int seen;
    do_op(DEF, 32'h7000, 32'h7000, 1'b0, 1'b0, lat, ok, s, co, ov);
    n_cmp++;
    if ({ov, co, s} !== {2'b10, 32'hE000}) begin n_err++; $display("FAIL rstrun_pre: got %h want 20000e000", {ov, co, s}); end
    @(negedge clk);
    a_in = 32'h1234; b_in = 32'h4321; sub_in = 1'b0; cin_in = 1'b0;
    start_v[DEF] = 1'b1;
    @(negedge clk);
    start_v[DEF] = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp += 2;
    if (sum_v[DEF] !== 32'h0) begin n_err++; $display("FAIL rstrun_sum_async: got %h want 0", sum_v[DEF]); end
    if ({busy_v[DEF], done_v[DEF], cout_v[DEF], ovf_v[DEF]} !== 4'b0000) begin
      n_err++; $display("FAIL rstrun_ctrl_async: got %b want 0000", {busy_v[DEF], done_v[DEF], cout_v[DEF], ovf_v[DEF]});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_v[DEF] || busy_v[DEF]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL rstrun_no_done: got %0d active cycles want 0", seen); end
    do_op(DEF, 32'h1234, 32'h4321, 1'b0, 1'b0, lat, ok, s, co, ov);
    n_cmp += 2;
    if ({ov, co, s} !== {2'b00, 32'h5555}) begin n_err++; $display("FAIL rstrun_fresh: got %h want 000005555", {ov, co, s}); end
    if (lat !== 4) begin n_err++; $display("FAIL rstrun_fresh_latency: got %0d want 4", lat); end
  endtask

  task automatic test_sweep();
    int lat; logic ok; logic [31:0] s; logic co, ov;
    logic [31:0] a, b; logic sb, c; logic [33:0] exp_v; logic [31:0] mask;
    int w;
    for (int i = 0; i < NCFG; i++) begin
      w = cfg_w(i);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      for (int k = 0; k < 1000; k++) begin
        a = rand_operand(w); b = rand_operand(w);
        sb = 1'($urandom); c = 1'($urandom);
        exp_v = ref_model(w, a, b, sb, c);
        do_op(i, a, b, sb, c, lat, ok, s, co, ov);
        n_cmp += 4;
        if (s !== exp_v[31:0]) begin n_err++; $display("FAIL sweep_sum cfg%0d a=%h b=%h sub=%b cin=%b: got %h want %h", i, a & mask, b & mask, sb, c, s, exp_v[31:0]); end
        if ({ov, co} !== exp_v[33:32]) begin n_err++; $display("FAIL sweep_flags cfg%0d a=%h b=%h sub=%b cin=%b: got ovf/cout %b want %b", i, a & mask, b & mask, sb, c, {ov, co}, exp_v[33:32]); end
        if (lat !== cfg_nch(i)) begin n_err++; $display("FAIL sweep_latency cfg%0d: got %0d want %0d", i, lat, cfg_nch(i)); end
        if (ok !== 1'b1) begin n_err++; $display("FAIL sweep_busy_window cfg%0d: got %b want 1", i, ok); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    start_v = '0;
    a_in = '0; b_in = '0; sub_in = 1'b0; cin_in = 1'b0;
    test_reset();
    test_basic_add();
    test_add_cases();
    test_sub_cases();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
